bus_rr_arbiter: RTL and testbench

Round-robin bus arbiter with burst limit and transfer watchdog for the 4-master / 8-slave shared bus. It replaces the fixed-priority grant logic in front of the master multiplexer. It drives the same active-low `mN_grnt_` lines and observes the shared `s_as_` / `m_rdy` handshake. From that handshake it counts completed beats, forces fair rotation, and revokes ownership from a master whose slave never answers.

---
 rtl/bus_rr_arbiter.sv | 101 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin grant for 4 masters with burst limit and optional (BUS_ARB_WDT_EN) transfer watchdog
//   clk, reset (async, active-high)
//   m0_req_..m3_req_ : active-low requests; s_as_ : active-low strobe; m_rdy : slave ready
//   m0_grnt_..m3_grnt_ : registered active-low grants; owner : granted master index
//   bus_err : timeout pulse; err_master : last master that timed out
module bus_rr_arbiter #(
  parameter int MAX_BEATS  = 16,
  parameter int TMO_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       s_as_,
  input  logic       m_rdy,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_err,
  output logic [1:0] err_master
);
  typedef enum logic [1:0] {IDLE, OWN, HAND} state_t;
  state_t state, state_n;
  logic [3:0] req_q, grnt, grnt_n;
  logic [1:0] last, last_n, owner_n, win;
  logic [7:0] beats, beats_n, beat_inc;
  logic beat, burst_hit, others, tmo;
  // Requests are registered, so decisions see the value sampled on the previous edge.
  always_comb begin
    win = last;
    for (int i = 4; i >= 1; i--) if (req_q[last + 2'(i)]) win = last + 2'(i);
  end
  assign beat      = state == OWN && !s_as_ && m_rdy;
  assign beat_inc  = beats + 8'd1;
  assign burst_hit = beat && beat_inc == 8'(MAX_BEATS);
  assign others    = |(req_q & ~(4'b0001 << owner));
`ifdef BUS_ARB_WDT_EN
  logic [7:0] wdt;
  logic stall;
  assign stall = state == OWN && !s_as_ && !m_rdy;
  assign tmo   = stall && wdt + 8'd1 == 8'(TMO_CYCLES);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wdt        <= '0;
      bus_err    <= 1'b0;
      err_master <= '0;
    end else begin
      wdt     <= stall && !tmo ? wdt + 8'd1 : 8'd0;
      bus_err <= tmo;
      if (tmo) err_master <= owner;
    end
`else
  assign tmo        = 1'b0;
  assign bus_err    = 1'b0;
  assign err_master = 2'd0;
`endif
  always_comb begin
    state_n = state;
    grnt_n  = grnt;
    owner_n = owner;
    last_n  = last;
    beats_n = beats;
    case (state)
      OWN: begin
        if (beat) beats_n = burst_hit ? 8'd0 : beat_inc;
        if (tmo || !req_q[owner] || (burst_hit && others)) begin
          state_n = HAND;
          grnt_n  = '0;
        end
      end
      default: begin
        state_n = |req_q ? OWN : IDLE;
        grnt_n  = |req_q ? 4'b0001 << win : 4'b0000;
        owner_n = |req_q ? win : owner;
        last_n  = |req_q ? win : last;
        beats_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      req_q <= '0;
      grnt  <= '0;
      owner <= '0;
      last  <= 2'd3;
      beats <= '0;
    end else begin
      state <= state_n;
      req_q <= ~{m3_req_, m2_req_, m1_req_, m0_req_};
      grnt  <= grnt_n;
      owner <= owner_n;
      last  <= last_n;
      beats <= beats_n;
    end
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = ~grnt;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: scoreboard bench for bus_rr_arbiter (MAX_BEATS=4, TMO_CYCLES=8)
module tb_bus_rr_arbiter;
  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       e;
    logic [1:0] em;
    int         c;
  } ev_t;
  logic clk = 0, reset = 0, s_as_ = 1, m_rdy = 0, bus_err;
  logic [3:0] req_n = 4'hf, g;
  logic [1:0] owner, err_master, em_exp = 0;
  logic [4:0] prev = 5'b11110;
  int cyc = 0, checks = 0, errors = 0;
  ev_t q[$];
  ev_t mev;
  bus_rr_arbiter #(.MAX_BEATS(4), .TMO_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .s_as_(s_as_), .m_rdy(m_rdy),
    .m0_grnt_(g[0]), .m1_grnt_(g[1]), .m2_grnt_(g[2]), .m3_grnt_(g[3]),
    .owner(owner), .bus_err(bus_err), .err_master(err_master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input logic [3:0] eg, input logic [1:0] eo, input logic ee, input int dc);
    ev_t ev;
    ev.g = eg; ev.o = eo; ev.e = ee; ev.em = em_exp; ev.c = cyc + dc;
    q.push_back(ev);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if ({g, bus_err} != prev) begin
      prev = {g, bus_err};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event grnt_=%b bus_err=%b cyc=%0d required no change", g, bus_err, cyc);
      end else begin
        mev = q.pop_front();
        if (g !== mev.g || bus_err !== mev.e || err_master !== mev.em || cyc != mev.c ||
            (mev.g != 4'hf && owner !== mev.o)) begin
          errors++;
          $display("FAIL event got grnt_=%b owner=%0d bus_err=%b err_master=%0d cyc=%0d required grnt_=%b owner=%0d bus_err=%b err_master=%0d cyc=%0d",
                   g, owner, bus_err, err_master, cyc, mev.g, mev.o, mev.e, mev.em, mev.c);
        end
      end
    end
  initial begin
    #1 reset = 1;
    tick(3);
    chk("reset_grnt", int'(g), 15);
    chk("reset_owner", int'(owner), 0);
    chk("reset_bus_err", int'(bus_err), 0);
    chk("reset_err_master", int'(err_master), 0);
    reset = 0;
    tick(1);
    // m2 alone: grant, then release back to idle
    req_n = 4'b1011;
    push(4'b1011, 2, 0, 2);
    tick(3);
    req_n = 4'hf;
    push(4'hf, 0, 0, 2);
    tick(4);
    // all request with back-to-back beats: burst limit rotates 3,0,1,2,3
    req_n = 4'h0; s_as_ = 0; m_rdy = 1;
    push(4'b0111, 3, 0, 2);  push(4'hf, 0, 0, 6);
    push(4'b1110, 0, 0, 7);  push(4'hf, 0, 0, 11);
    push(4'b1101, 1, 0, 12); push(4'hf, 0, 0, 16);
    push(4'b1011, 2, 0, 17); push(4'hf, 0, 0, 21);
    push(4'b0111, 3, 0, 22);
    tick(22);
    req_n = 4'hf; s_as_ = 1; m_rdy = 0;
    push(4'hf, 0, 0, 2);
    tick(4);
    // m1 bursting while m3 waits: rotation after the 4th beat
    req_n = 4'b0101; s_as_ = 0; m_rdy = 1;
    push(4'b1101, 1, 0, 2); push(4'hf, 0, 0, 6); push(4'b0111, 3, 0, 7);
    tick(7);
    req_n = 4'hf; s_as_ = 1; m_rdy = 0;
    push(4'hf, 0, 0, 2);
    tick(4);
    // m1 alone 10 beats keeps the bus; counter wrapped so 2 more beats trigger rotation
    req_n = 4'b1101; s_as_ = 0; m_rdy = 1;
    push(4'b1101, 1, 0, 2);
    tick(12);
    req_n = 4'b0101;
    push(4'hf, 0, 0, 2); push(4'b0111, 3, 0, 3);
    tick(3);
    req_n = 4'hf; s_as_ = 1; m_rdy = 0;
    push(4'hf, 0, 0, 2);
    tick(4);
    // m2 owns with a stalled slave
    req_n = 4'b1011; s_as_ = 0; m_rdy = 0;
    push(4'b1011, 2, 0, 2);
`ifdef BUS_ARB_WDT_EN
    em_exp = 2;
    push(4'hf, 2, 1, 10); push(4'b1011, 2, 0, 11);
    tick(11);
`else
    tick(300);
`endif
    req_n = 4'hf; s_as_ = 1;
    push(4'hf, 0, 0, 2);
    tick(4);
    // reset two cycles into m3's tenure, then m0 beats m3
    req_n = 4'b0111;
    push(4'b0111, 3, 0, 2);
    tick(4);
    em_exp = 0;
    push(4'hf, 0, 0, 0);
    reset = 1;
    #1;
    chk("async_reset_grnt", int'(g), 15);
    chk("async_reset_bus_err", int'(bus_err), 0);
    chk("async_reset_err_master", int'(err_master), 0);
    tick(2);
    reset = 0; req_n = 4'b0110;
    push(4'b1110, 0, 0, 2);
    tick(2);
    req_n = 4'hf;
    push(4'hf, 0, 0, 2);
    tick(4);
    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
